instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction prefetcher: credit-limited requests, in-order response queue, redirect drain.
// Optional FETCH_PERF_EN adds fetch_cnt/stall_cnt performance counters.
module instr_fetch_unit #(
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc8
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     stale_q, stale_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [DATA_W-1:0] qdata_q [DEPTH];
    logic [ADDR_W-1:0] qpc_q [DEPTH];

    logic              accept, rv_ok, drop, push, pop;
    logic [CW:0]       used;
    logic [ADDR_W-1:0] rsp_pc;

    assign used      = {1'b0, count_q} + {1'b0, inflight_q};
    assign imem_req  = (state_q == FETCH) && (used < (CW+1)'(DEPTH));
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_gnt;
    assign rv_ok     = (state_q == FETCH) && imem_rvalid && (inflight_q != '0);
    assign drop      = (state_q == DRAIN) && imem_rvalid && (stale_q != '0);
    assign push      = rv_ok && !redirect;
    assign pop       = out_valid && out_ready && !redirect;

    // Responses return in order, so the oldest in-flight PC trails the fetch PC.
    assign rsp_pc = pc_q - (ADDR_W'(inflight_q) << 2);

    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? qdata_q[rptr_q] : '0;
    assign out_pc    = out_valid ? qpc_q[rptr_q] : '0;
    assign out_pc8   = out_pc + ADDR_W'(8);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_q;
        stale_d    = stale_q;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (accept) pc_d = pc_q + ADDR_W'(4);
                inflight_d = inflight_q + CW'(accept) - CW'(rv_ok);
            end
            DRAIN: begin
                stale_d = stale_q - CW'(drop);
                if (stale_d == '0) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
        // A request granted in the redirect cycle still returns, so it is stale too.
        if (redirect) begin
            pc_d       = redirect_pc;
            inflight_d = '0;
            if (state_q == FETCH)
                stale_d = inflight_q + CW'(accept) - CW'(rv_ok);
            else if (state_q == IDLE)
                stale_d = '0;
            state_d = (stale_d != '0) ? DRAIN : FETCH;
        end
        count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
        wptr_d  = redirect ? '0 : wptr_q + AW'(push);
        rptr_d  = redirect ? '0 : rptr_q + AW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VEC;
            inflight_q <= '0;
            stale_q    <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qdata_q[wptr_q] <= imem_rdata;
            qpc_q[wptr_q]   <= rsp_pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop) fetch_cnt <= fetch_cnt + 32'd1;
            if (out_ready && !out_valid) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
